// File: rtl/regbank_write_arbiter_if.sv
// Writeback request bus between the writeback sources and the register bank write arbiter.
// Each requester's address and data are packed side by side, with requester i at index i.
interface regbank_write_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;

    modport master (output req, output addr, output data, input gnt);
    modport slave  (input req, input addr, input data, output gnt);
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// The winner's address is decoded to a one-hot select and sent to the bank with its data on a registered port.
module regbank_write_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    regbank_write_arbiter_if.slave bus,
    output logic [(2**AW)-1:0]     select,
    output logic [DW-1:0]          Din,
    output logic                   we,
    output logic                   busy
);
    localparam int LW   = $clog2(NREQ);
    localparam int NSEL = 2**AW;
    localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [NSEL-1:0] SEL_ONE = {{(NSEL-1){1'b0}}, 1'b1};

    logic [LW-1:0]   last_r;
    logic [LW-1:0]   win_s;
    logic [LW-1:0]   cand_s;
    logic            hit_s;
    logic            xfer_s;
    logic [NREQ-1:0] gnt_s;
    logic [AW-1:0]   waddr_s;
    logic [DW-1:0]   wdata_s;

    // Winner search starts one past the last winner; it reads only req, en, rst and last_r.
    always_comb begin
        win_s  = last_r;
        cand_s = last_r;
        hit_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = LW'((int'(last_r) + k) % NREQ);
            win_s  = (!hit_s && bus.req[cand_s]) ? cand_s : win_s;
            hit_s  = hit_s | bus.req[cand_s];
        end
        xfer_s  = hit_s & en & rst;
        gnt_s   = xfer_s ? (GNT_ONE << win_s) : {NREQ{1'b0}};
        bus.gnt = gnt_s;
        waddr_s = bus.addr[int'(win_s)*AW +: AW];
        wdata_s = bus.data[int'(win_s)*DW +: DW];
    end

    // Register the bank write port and the priority pointer. Din holds its value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= LW'(NREQ - 1);
            we     <= 1'b0;
            select <= {NSEL{1'b0}};
            Din    <= {DW{1'b0}};
            busy   <= 1'b0;
        end else begin
            busy <= |(bus.req & ~gnt_s);
            if (xfer_s) begin
                last_r <= win_s;
                we     <= 1'b1;
                select <= SEL_ONE << waddr_s;
                Din    <= wdata_s;
            end else begin
                we     <= 1'b0;
                select <= {NSEL{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: a two-requester instance checked through a write scoreboard,
// plus a four-requester instance that exercises skipping an idle requester.
module tb_regbank_write_arbiter;
    typedef struct packed {
        logic        we;
        logic [15:0] sel;
        logic [31:0] din;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst;
    logic en2;
    logic en4;
    logic [15:0] sel2;
    logic [31:0] din2;
    logic        we2;
    logic        busy2;
    logic [15:0] sel4;
    logic [31:0] din4;
    logic        we4;
    logic        busy4;

    int checks;
    int errors;
    logic [31:0] model_din;
    exp_t q2[$];
    exp_t q4[$];

    regbank_write_arbiter_if #(.NREQ(2), .DW(32), .AW(4)) bus2 ();
    regbank_write_arbiter_if #(.NREQ(4), .DW(32), .AW(4)) bus4 ();

    regbank_write_arbiter #(.NREQ(2), .DW(32), .AW(4)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .bus(bus2.slave),
        .select(sel2), .Din(din2), .we(we2), .busy(busy2)
    );

    regbank_write_arbiter #(.NREQ(4), .DW(32), .AW(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .bus(bus4.slave),
        .select(sel4), .Din(din4), .we(we4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset for one edge; all outputs must clear without waiting for the clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_gnt2", 64'(bus2.gnt), 64'h0);
        check("rst_we", 64'(we2), 64'h0);
        check("rst_sel", 64'(sel2), 64'h0);
        check("rst_din", 64'(din2), 64'h0);
        check("rst_busy", 64'(busy2), 64'h0);
        model_din = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One cycle on the 2-requester DUT: check gnt mid-cycle, push the expected bank port, compare after the edge.
    task automatic step2(input string tag, input logic [1:0] eg);
        exp_t e;
        exp_t got;
        @(negedge clk);
        check({tag, "_gnt"}, 64'(bus2.gnt), 64'(eg));
        e.busy = |(bus2.req & ~eg);
        if (eg == 2'b01) begin
            e.we = 1'b1; e.sel = 16'h0001 << bus2.addr[3:0]; e.din = bus2.data[31:0];
        end else if (eg == 2'b10) begin
            e.we = 1'b1; e.sel = 16'h0001 << bus2.addr[7:4]; e.din = bus2.data[63:32];
        end else begin
            e.we = 1'b0; e.sel = 16'h0000; e.din = model_din;
        end
        model_din = e.din;
        q2.push_back(e);
        @(posedge clk);
        #1;
        got = q2.pop_front();
        check({tag, "_we"}, 64'(we2), 64'(got.we));
        check({tag, "_sel"}, 64'(sel2), 64'(got.sel));
        check({tag, "_din"}, 64'(din2), 64'(got.din));
        check({tag, "_busy"}, 64'(busy2), 64'(got.busy));
    endtask

    // One cycle on the 4-requester DUT; the expected select is given by the caller.
    task automatic step4(input string tag, input logic [3:0] eg, input logic [15:0] esel);
        exp_t e;
        exp_t got;
        @(negedge clk);
        check({tag, "_gnt"}, 64'(bus4.gnt), 64'(eg));
        e.we = 1'b1; e.sel = esel; e.din = 32'h0; e.busy = 1'b1;
        q4.push_back(e);
        @(posedge clk);
        #1;
        got = q4.pop_front();
        check({tag, "_we"}, 64'(we4), 64'(got.we));
        check({tag, "_sel"}, 64'(sel4), 64'(got.sel));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_din = 32'h0;
        en2 = 1'b0; en4 = 1'b0;
        bus2.req = 2'b00; bus2.addr = 8'h00; bus2.data = 64'h0;
        bus4.req = 4'b0000; bus4.addr = 16'h0000; bus4.data = 128'h0;
        rst = 1'b1;
        #2;
        do_reset();

        // Single request, then idle: Din holds.
        en2 = 1'b1;
        bus2.req = 2'b01; bus2.addr = 8'h03; bus2.data = {32'h0, 32'h0000_000A};
        step2("single", 2'b01);
        bus2.req = 2'b00;
        step2("idle", 2'b00);
        check("hold_din", 64'(din2), 64'h0A);

        // Both requesters: strict alternation starting at requester 0.
        do_reset();
        bus2.req = 2'b11; bus2.addr = {4'd2, 4'd1}; bus2.data = {32'd12, 32'd11};
        step2("rr0", 2'b01);
        step2("rr1", 2'b10);
        step2("rr2", 2'b01);
        step2("rr3", 2'b10);
        bus2.req = 2'b00;
        step2("rr_idle", 2'b00);

        // en low holds the request pending; arbitration resumes from requester 0.
        do_reset();
        en2 = 1'b0;
        bus2.req = 2'b11;
        for (int i = 0; i < 3; i++) step2("en_off", 2'b00);
        en2 = 1'b1;
        step2("en_on", 2'b01);
        bus2.req = 2'b00;
        step2("en_idle", 2'b00);

        // Back-to-back address sweep from requester 0.
        bus2.req = 2'b01; bus2.addr[7:4] = 4'd0;
        for (int a = 0; a < 16; a++) begin
            bus2.addr[3:0] = 4'(a);
            bus2.data[31:0] = 32'(100 + a);
            step2("sweep", 2'b01);
        end

        // Second sweep interrupted by reset at address 7.
        for (int a = 0; a < 7; a++) begin
            bus2.addr[3:0] = 4'(a);
            bus2.data[31:0] = 32'(100 + a);
            step2("sweep_b", 2'b01);
        end
        bus2.addr[3:0] = 4'd7;
        bus2.data[31:0] = 32'd107;
        @(negedge clk);
        check("mid_gnt", 64'(bus2.gnt), 64'h1);
        @(posedge clk);
        #1;
        check("mid_sel", 64'(sel2), 64'h0080);
        #2;
        rst = 1'b0;
        #1;
        check("async_we", 64'(we2), 64'h0);
        check("async_sel", 64'(sel2), 64'h0);
        check("async_din", 64'(din2), 64'h0);
        check("async_gnt", 64'(bus2.gnt), 64'h0);
        model_din = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int a = 8; a < 16; a++) begin
            bus2.addr[3:0] = 4'(a);
            bus2.data[31:0] = 32'(100 + a);
            step2("sweep_c", 2'b01);
        end
        bus2.req = 2'b00;
        en2 = 1'b0;

        // Four requesters with requester 2 idle: it is skipped.
        do_reset();
        en4 = 1'b1;
        bus4.req = 4'b1011;
        bus4.addr = {4'd3, 4'd2, 4'd1, 4'd0};
        step4("n4_0", 4'b0001, 16'h0001);
        step4("n4_1", 4'b0010, 16'h0002);
        step4("n4_2", 4'b1000, 16'h0008);
        step4("n4_3", 4'b0001, 16'h0001);
        bus4.req = 4'b0000;
        en4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin arbiter and sequencer for the single write port of the 16 x 32-bit register bank (`Registers`). Up to NREQ writeback sources (ALU, load unit, ...) present write requests with valid/ready handshakes. One request is granted per cycle, and the winner's address is decoded into the bank's one-hot `select`. The registered `select`/`Din`/`we` outputs drive the bank directly.

## Interface
- NREQ, 2: number of requesters, legal range 2..4
- DW, 32: data width, matches bank `Din`
- AW, 4: register address width; bank depth is 2^AW = 16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  grant enable; when 0, no grants are issued and outputs idle
- req  in  NREQ  per-requester valid
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- data  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- gnt  out  NREQ  per-requester ready, combinational, one-hot or zero
- select  out  2^AW  one-hot register select to bank, registered
- Din  out  DW  write data to bank, registered
- we  out  1  write strobe to bank, registered
- busy  out  1  registered; 1 if any req was refused (req & ~gnt) in the previous cycle

## Operation
- Transfer: requester i completes a transfer at a rising edge where req[i] & gnt[i] = 1.
  - Requester holds addr/data stable while req[i]=1 and gnt[i]=0.
  - After a transfer, the requester may present a new request in the next cycle.
- Arbitration (combinational):
  - Pointer `last` (AW-independent, width clog2(NREQ)) holds the index of the most recent winner.
  - Search order is last+1, last+2, ... modulo NREQ. The first requester with req=1 wins.
  - gnt = 0 when en=0 or rst=0.
- On each transfer edge:
  - last <= winner
  - we <= 1
  - select <= 1 << addr[winner]
  - Din <= data[winner]
- On an edge with no transfer: we <= 0, select <= 0, Din holds its previous value.
- busy <= |(req & ~gnt) on every edge.
- Address decode: addr is an unsigned value 0..15. Every value is legal; there are no reserved registers.
- Single requester active: it is granted every cycle, with no bubble.
- All requesters active: grants rotate strictly, 0,1,..,NREQ-1,0,...
- en falling while a req is pending: no grant, and the request stays pending. Arbitration resumes from the unchanged `last` when en returns to 1.

## Timing
- Reset (rst=0, asynchronous): last = NREQ-1 (requester 0 has first priority), we=0, select=0, Din=0, busy=0, gnt=0.
- Reset release: the first grant is possible in the first cycle with rst=1 and en=1.
- Latency: transfer at edge N -> select/Din/we valid in the cycle after edge N. The bank captures them at edge N+1.
- Throughput: one write per cycle sustained.
- Reset mid-operation: gnt drops immediately (combinationally). we/select clear asynchronously. A write registered before the reset assertion is lost if reset asserts before the bank edge.
- Two requesters targeting the same register in consecutive cycles: both writes are issued in grant order, so the later grant's data persists.
- gnt depends only on req, en, rst and `last`. There is no combinational path from addr/data to gnt.

## Test plan
- Reset, then req=01, addr0=3, data0=32'h0000_000A held 1 cycle:
  - gnt=01 in the same cycle.
  - The next cycle shows we=1, select=16'h0008, Din=10.
  - The cycle after shows we=0, select=0, Din=10.
- NREQ=2, both req held 4 cycles, addr0=1/data0=11, addr1=2/data1=12:
  - gnt sequence 01,10,01,10.
  - select sequence 0002,0004,0002,0004 one cycle later.
  - busy=1 from the second cycle onward.
- en=0 for 3 cycles with req=11: gnt=00, we=0, busy=1. Raising en gives gnt=01 first (last still 1 after reset).
- Sweep addr0 = 0..15 on back-to-back cycles with data0 = 100+addr: select walks 0001..8000 one-hot each cycle, Din = 100..115, we stays 1 for 16 cycles.
- Assert rst=0 mid-sweep at addr 7: we, select, Din clear without waiting for clk, gnt=0. After release, requester 0 at addr 8 is granted first.
- NREQ=4, req=1011 held: gnt order 0001,0010,1000,0001 (requester 2 skipped).
